// File: rtl/icache_line_responder.sv
// L2-side line responder: assembles one WORDS x 16-bit line from sequential pmem word reads.
// Optional one-entry line buffer enabled by defining ICACHE_LINE_BUF_EN.
module icache_line_responder #(
  parameter int WORDS       = 8,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l2_read,
  input  logic [15:0]           l2_addr,
  output logic                  l2_resp,
  output logic [16*WORDS-1:0]   l2_rdata,
  output logic                  pmem_read,
  output logic [15:0]           pmem_address,
  input  logic                  pmem_resp,
  input  logic [15:0]           pmem_rdata,
  input  logic                  buf_inval
);

  localparam int CNT_BITS = OFFSET_BITS - 1;
  localparam int TAG_BITS = 16 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, RESPOND, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [TAG_BITS-1:0]   line_addr;
  logic [CNT_BITS-1:0]   cnt;
  logic [16*WORDS-1:0]   line_data;
  logic                  last_word;
  logic                  buf_hit;
  logic                  unused_low;

  assign last_word  = (cnt == CNT_BITS'(WORDS - 1));
  assign unused_low = ^l2_addr[OFFSET_BITS-1:0];

`ifdef ICACHE_LINE_BUF_EN
  logic                  buf_valid;
  logic [TAG_BITS-1:0]   buf_tag;

  assign buf_hit = buf_valid && (buf_tag == l2_addr[15:OFFSET_BITS]);

  // line_data itself holds the buffered line; invalidate beats a concurrent fill completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else begin
      if (buf_inval)
        buf_valid <= 1'b0;
      else if (state == RESPOND)
        buf_valid <= 1'b1;
      if (state == RESPOND)
        buf_tag <= line_addr;
    end
  end
`else
  logic unused_inval;

  assign buf_hit      = 1'b0;
  assign unused_inval = buf_inval;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (l2_read)
          next_state = buf_hit ? RESPOND : FETCH;
      end
      FETCH: begin
        if (pmem_resp && last_word)
          next_state = RESPOND;
      end
      RESPOND: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counter saturates at the last word; the line is only rewritten once a new fill starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_addr <= '0;
      cnt       <= '0;
      line_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l2_read) begin
            line_addr <= l2_addr[15:OFFSET_BITS];
            cnt       <= '0;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            line_data[{cnt, 4'b0000} +: 16] <= pmem_rdata;
            if (!last_word)
              cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    l2_resp      = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    l2_rdata     = line_data;
    case (state)
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {line_addr, cnt, 1'b0};
      end
      RESPOND: l2_resp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_line_responder.sv
// Self-checking bench for icache_line_responder: memory model plus address/line scoreboard.
// Buffer scenarios are compiled in when ICACHE_LINE_BUF_EN is defined.
module tb_icache_line_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         l2_read;
  logic [15:0]  l2_addr;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_resp = 1'b0;
  logic [15:0]  pmem_rdata = '0;
  logic         buf_inval;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  int wait_states = 0;
  int wait_cnt    = 0;
  int words_done  = 0;

  logic [15:0]  exp_addr_q[$];
  logic [127:0] exp_line_q[$];

  always #5 clk = ~clk;

  icache_line_responder dut (
    .clk          (clk),
    .reset        (reset),
    .l2_read      (l2_read),
    .l2_addr      (l2_addr),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .buf_inval    (buf_inval)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] lineFor(input logic [15:0] addr);
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < 8; i++)
      l[16*i +: 16] = {addr[15:4], 3'(i), 1'b0};
    return l;
  endfunction

  // Memory returns word = address after wait_states extra cycles; also scores addresses and lines
  always @(negedge clk) begin
    if (pmem_read) begin
      if (exp_addr_q.size() == 0)
        checkOutput("pmem_read_unexpected", {127'b0, pmem_read}, 128'd0);
      else
        checkOutput("pmem_address", {112'b0, pmem_address}, {112'b0, exp_addr_q[0]});
      if (wait_cnt >= wait_states) begin
        pmem_resp  = 1'b1;
        pmem_rdata = pmem_address;
        wait_cnt   = 0;
        words_done++;
        if (exp_addr_q.size() != 0)
          void'(exp_addr_q.pop_front());
      end else begin
        pmem_resp = 1'b0;
        wait_cnt++;
      end
    end else begin
      pmem_resp = 1'b0;
      wait_cnt  = 0;
    end
    if (l2_resp) begin
      if (exp_line_q.size() == 0)
        checkOutput("l2_resp_unexpected", {127'b0, l2_resp}, 128'd0);
      else
        checkOutput("l2_rdata", l2_rdata, exp_line_q.pop_front());
    end
  end

  // Latency counts the accept cycle as cycle 1; hold_extra keeps l2_read high past the DONE cycle
  task automatic applyStimulus(input logic [15:0] addr, input bit hit, input int exp_lat, input bit hold_extra);
    int cycles;
    bit seen;
    @(negedge clk);
    if (!hit)
      for (int i = 0; i < 8; i++)
        exp_addr_q.push_back({addr[15:4], 3'(i), 1'b0});
    exp_line_q.push_back(lineFor(addr));
    l2_read = 1'b1;
    l2_addr = addr;
    cycles  = 1;
    seen    = 1'b0;
    while (!seen && cycles < 400) begin
      @(negedge clk);
      cycles++;
      l2_addr = addr ^ 16'hF0F0;
      if (l2_resp)
        seen = 1'b1;
    end
    checkOutput("l2_resp_seen", {127'b0, seen}, 128'd1);
    if (seen)
      checkOutput("latency", 128'(cycles), 128'(exp_lat));
    @(negedge clk);
    checkOutput("l2_resp_width", {127'b0, l2_resp}, 128'd0);
    if (hold_extra)
      @(negedge clk);
    l2_read = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset     = 1'b1;
    l2_read   = 1'b0;
    l2_addr   = '0;
    buf_inval = 1'b0;
    #12;
    checkOutput("reset_l2_resp",   {127'b0, l2_resp},   128'd0);
    checkOutput("reset_pmem_read", {127'b0, pmem_read}, 128'd0);
    checkOutput("reset_pmem_addr", {112'b0, pmem_address}, 128'd0);
    checkOutput("reset_l2_rdata",  l2_rdata, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] zero-wait fill 0x1234");
    wait_states = 0;
    applyStimulus(16'h1234, 1'b0, 10, 1'b0);

    $display("[TB] wait-state fill 0x1234");
    wait_states = 2;
    applyStimulus(16'h1234, 1'b0, 26, 1'b0);
    wait_states = 0;

    $display("[TB] l2_read held through DONE");
    applyStimulus(16'h4450, 1'b0, 10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_refill", {127'b0, pmem_read}, 128'd0);
    end
    applyStimulus(16'h8000, 1'b0, 10, 1'b0);

    $display("[TB] reset after 4th word");
    words_done = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      exp_addr_q.push_back({12'h100, 3'(i), 1'b0});
    l2_read = 1'b1;
    l2_addr = 16'h1000;
    n = 0;
    while (words_done < 4 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("four_words_fetched", 128'(words_done), 128'd4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_pmem_read", {127'b0, pmem_read}, 128'd0);
    checkOutput("async_pmem_addr", {112'b0, pmem_address}, 128'd0);
    checkOutput("async_l2_rdata",  l2_rdata, 128'd0);
    exp_addr_q.delete();
    exp_line_q.delete();
    l2_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(16'h0040, 1'b0, 10, 1'b0);

`ifdef ICACHE_LINE_BUF_EN
    $display("[TB] line buffer hit / invalidate / miss");
    applyStimulus(16'h2000, 1'b0, 10, 1'b0);
    applyStimulus(16'h2006, 1'b1, 2, 1'b0);
    @(negedge clk);
    buf_inval = 1'b1;
    @(negedge clk);
    buf_inval = 1'b0;
    applyStimulus(16'h2000, 1'b0, 10, 1'b0);
    applyStimulus(16'h2010, 1'b0, 10, 1'b0);
    applyStimulus(16'h2018, 1'b1, 2, 1'b0);
    buf_inval = 1'b1;
    applyStimulus(16'h3000, 1'b0, 10, 1'b0);
    buf_inval = 1'b0;
    applyStimulus(16'h3000, 1'b0, 10, 1'b0);
`else
    $display("[TB] repeat request always refetches");
    buf_inval = 1'b1;
    applyStimulus(16'h8000, 1'b0, 10, 1'b0);
    buf_inval = 1'b0;
    applyStimulus(16'h8004, 1'b0, 10, 1'b0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("addr_queue_drained", 128'(exp_addr_q.size()), 128'd0);
    checkOutput("line_queue_drained", 128'(exp_line_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
